// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the step sequence controller: default counter width,
// state encoding and the maximum sequence length.
package seq_ctrl_pkg;

  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned MAX_STEPS = 2 ** DEF_CNT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/step_sequence_controller.sv
// Sequencing FSM in front of an external step counter: clears the counter, issues one
// valid/ready step per count value up to a latched length, then pulses done.
module step_sequence_controller
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W:0]   num_steps,
  input  logic [CNT_W-1:0] count,
  output logic             count_enable,
  output logic             counter_reset,
  output logic             step_valid,
  input  logic             step_ready,
  output logic [CNT_W-1:0] step_idx,
  output logic             last_step,
  output logic             busy,
  output logic             done
);

  // Longest sequence the counter can index: 2**CNT_W.
  localparam logic [CNT_W:0] MaxLen = {1'b1, {CNT_W{1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W:0]   len_q, len_d;
  logic             last_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // len_q is never 0 in RUN, so len_q - 1 cannot underflow where it matters.
  assign last_match = ({1'b0, count} == (len_q - 1'b1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    count_enable  = 1'b0;
    counter_reset = 1'b0;
    step_valid    = 1'b0;
    step_idx      = '0;
    last_step     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    // Outputs are held low for the whole reset cycle regardless of current state.
    if (!reset) begin
      if (state_q != S_IDLE && abort) begin
        counter_reset = 1'b1;
        busy          = 1'b1;
        state_d       = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              len_d   = (num_steps > MaxLen) ? MaxLen : num_steps;
              state_d = (num_steps == '0) ? S_DONE : S_CLEAR;
            end
          end
          S_CLEAR: begin
            counter_reset = 1'b1;
            busy          = 1'b1;
            state_d       = S_RUN;
          end
          S_RUN: begin
            busy         = 1'b1;
            step_valid   = 1'b1;
            step_idx     = count;
            last_step    = last_match;
            count_enable = step_ready;
            if (step_ready && last_match) begin
              state_d = S_DONE;
            end
          end
          S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_sequence_controller.sv
// Bench for step_sequence_controller with a behavioural four_bit_counter beside it:
// cycle-by-cycle vector table plus hand-written long, abort and reset sequences.
module tb_step_sequence_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] num_steps;
  logic [3:0] count;
  logic       count_enable;
  logic       counter_reset;
  logic       step_valid;
  logic       step_ready;
  logic [3:0] step_idx;
  logic       last_step;
  logic       busy;
  logic       done;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  step_sequence_controller #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_steps    (num_steps),
    .count        (count),
    .count_enable (count_enable),
    .counter_reset(counter_reset),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .step_idx     (step_idx),
    .last_step    (last_step),
    .busy         (busy),
    .done         (done)
  );

  // four_bit_counter stand-in: synchronous clear, increment on enable, wraps 15->0.
  always_ff @(posedge clk) begin
    if (reset || counter_reset) count <= '0;
    else if (count_enable)      count <= count + 4'd1;
  end

  typedef struct packed {
    logic       cr;
    logic       ce;
    logic       sv;
    logic [3:0] idx;
    logic       last;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic       ready;
    logic [4:0] ns;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic a, logic r, logic [4:0] ns, logic cr, logic ce,
                              logic sv, logic [3:0] idx, logic last, logic b, logic d,
                              logic [3:0] cnt);
    vec_t v;
    v.start = s;  v.abort = a;  v.ready = r;  v.ns = ns;
    v.exp   = '{cr: cr, ce: ce, sv: sv, idx: idx, last: last, busy: b, done: d, cnt: cnt};
    return v;
  endfunction

  function automatic obs_t sample();
    return '{cr: counter_reset, ce: count_enable, sv: step_valid, idx: step_idx,
             last: last_step, busy: busy, done: done, cnt: count};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic a, input logic r, input logic [4:0] ns);
    @(negedge clk);
    start = s;  abort = a;  step_ready = r;  num_steps = ns;
    #1;
  endtask

  task automatic run_long(input logic [4:0] ns);
    int ndone;
    drive(1'b1, 1'b0, 1'b1, ns);
    chk($sformatf("long%0d_idle", ns), {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, ns);
    chk($sformatf("long%0d_clear", ns), {31'd0, counter_reset}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, ns);
      chk($sformatf("long%0d_step%0d", ns, i), {26'd0, step_valid, step_idx, last_step},
          {26'd0, 1'b1, 4'(i), (i == 15)});
    end
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, ns);
      if (done) ndone++;
      if (i == 0) chk($sformatf("long%0d_done", ns), {30'd0, done, step_valid}, 32'b10);
    end
    chk($sformatf("long%0d_done_once", ns), ndone, 32'd1);
    chk($sformatf("long%0d_idle_after", ns), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;  start = 1'b1;  abort = 1'b0;  step_ready = 1'b1;  num_steps = 5'd3;

    // Reset: start held high must not leak through while reset is asserted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (i == 5) chk("reset_hold", sample(), obs_t'(0));
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    reset = 1'b0;
    #1;
    chk("reset_release", sample(), obs_t'(0));

    //          s  a  r  ns     cr ce sv idx last b  d  cnt
    // num_steps=5, ready always high
    vecs.push_back(mk(1, 0, 1, 5'd5, 0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 5'd5, 1, 0, 0, 4'd0, 0, 1, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 1, 1, 4'd0, 0, 1, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 1, 1, 4'd1, 0, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 1, 1, 4'd2, 0, 1, 0, 4'd2));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 1, 1, 4'd3, 0, 1, 0, 4'd3));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 1, 1, 4'd4, 1, 1, 0, 4'd4));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 0, 0, 4'd0, 0, 1, 1, 4'd5));
    vecs.push_back(mk(0, 0, 1, 5'd5, 0, 0, 0, 4'd0, 0, 0, 0, 4'd5));
    // num_steps=4, stall 3 cycles at idx 2; num_steps change after start is ignored
    vecs.push_back(mk(1, 0, 1, 5'd4, 0, 0, 0, 4'd0, 0, 0, 0, 4'd5));
    vecs.push_back(mk(0, 0, 1, 5'd9, 1, 0, 0, 4'd0, 0, 1, 0, 4'd5));
    vecs.push_back(mk(0, 0, 1, 5'd9, 0, 1, 1, 4'd0, 0, 1, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 5'd9, 0, 1, 1, 4'd1, 0, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 0, 5'd9, 0, 0, 1, 4'd2, 0, 1, 0, 4'd2));
    vecs.push_back(mk(0, 0, 0, 5'd9, 0, 0, 1, 4'd2, 0, 1, 0, 4'd2));
    vecs.push_back(mk(0, 0, 0, 5'd9, 0, 0, 1, 4'd2, 0, 1, 0, 4'd2));
    vecs.push_back(mk(0, 0, 1, 5'd9, 0, 1, 1, 4'd2, 0, 1, 0, 4'd2));
    vecs.push_back(mk(0, 0, 1, 5'd9, 0, 1, 1, 4'd3, 1, 1, 0, 4'd3));
    vecs.push_back(mk(0, 0, 1, 5'd9, 0, 0, 0, 4'd0, 0, 1, 1, 4'd4));
    vecs.push_back(mk(0, 0, 1, 5'd9, 0, 0, 0, 4'd0, 0, 0, 0, 4'd4));
    // num_steps=0: straight to DONE, no counter clear, no steps
    vecs.push_back(mk(1, 0, 1, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd4));
    vecs.push_back(mk(0, 0, 1, 5'd0, 0, 0, 0, 4'd0, 0, 1, 1, 4'd4));
    vecs.push_back(mk(0, 0, 1, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 4'd4));
    // start held while busy and in DONE: only one sequence
    vecs.push_back(mk(1, 0, 1, 5'd2, 0, 0, 0, 4'd0, 0, 0, 0, 4'd4));
    vecs.push_back(mk(1, 0, 1, 5'd2, 1, 0, 0, 4'd0, 0, 1, 0, 4'd4));
    vecs.push_back(mk(1, 0, 1, 5'd2, 0, 1, 1, 4'd0, 0, 1, 0, 4'd0));
    vecs.push_back(mk(1, 0, 1, 5'd2, 0, 1, 1, 4'd1, 1, 1, 0, 4'd1));
    vecs.push_back(mk(1, 0, 1, 5'd2, 0, 0, 0, 4'd0, 0, 1, 1, 4'd2));
    vecs.push_back(mk(0, 0, 1, 5'd2, 0, 0, 0, 4'd0, 0, 0, 0, 4'd2));
    // abort ignored in IDLE
    vecs.push_back(mk(0, 1, 1, 5'd2, 0, 0, 0, 4'd0, 0, 0, 0, 4'd2));
    // abort in CLEAR
    vecs.push_back(mk(1, 0, 1, 5'd3, 0, 0, 0, 4'd0, 0, 0, 0, 4'd2));
    vecs.push_back(mk(0, 1, 1, 5'd3, 1, 0, 0, 4'd0, 0, 1, 0, 4'd2));
    vecs.push_back(mk(0, 0, 1, 5'd3, 0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
    // abort in DONE suppresses done
    vecs.push_back(mk(1, 0, 1, 5'd1, 0, 0, 0, 4'd0, 0, 0, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 5'd1, 1, 0, 0, 4'd0, 0, 1, 0, 4'd0));
    vecs.push_back(mk(0, 0, 1, 5'd1, 0, 1, 1, 4'd0, 1, 1, 0, 4'd0));
    vecs.push_back(mk(0, 1, 1, 5'd1, 1, 0, 0, 4'd0, 0, 1, 0, 4'd1));
    vecs.push_back(mk(0, 0, 1, 5'd1, 0, 0, 0, 4'd0, 0, 0, 0, 4'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].ready, vecs[i].ns);
      chk($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    // Lengths at and above 2**CNT_W both clamp to 16 steps.
    run_long(5'd16);
    run_long(5'd20);

    // Abort at idx 6 of 10 with ready high: abort wins over the handshake.
    drive(1'b1, 1'b0, 1'b1, 5'd10);
    drive(1'b0, 1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd10);
      chk($sformatf("abort_pre%0d", i), {27'd0, step_valid, step_idx}, {27'd0, 1'b1, 4'(i)});
    end
    drive(1'b0, 1'b1, 1'b1, 5'd10);
    chk("abort_cycle", {22'd0, counter_reset, count_enable, step_valid, done, busy, 1'b0, count},
        {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6});
    drive(1'b0, 1'b0, 1'b1, 5'd10);
    chk("abort_after", {24'd0, step_valid, busy, counter_reset, done, count},
        {24'd0, 4'b0000, 4'd0});
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd10);
      chk($sformatf("abort_no_done%0d", i), {30'd0, done, step_valid}, 32'd0);
    end
    drive(1'b1, 1'b0, 1'b1, 5'd3);
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    chk("restart_clear", {31'd0, counter_reset}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    chk("restart_first", {27'd0, step_valid, step_idx}, {27'd0, 1'b1, 4'd0});

    // Reset mid-sequence: outputs low during the reset cycle, IDLE afterwards.
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    reset = 1'b1;
    #1;
    chk("midreset_cycle", sample(), obs_t'({11'd0, 4'd1}));
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    reset = 1'b0;
    #1;
    chk("midreset_after", sample(), obs_t'(0));
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    chk("midreset_idle", {30'd0, busy, step_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
